// File: rtl/zacore_common.sv
// Shared types for the zacore memory subsystem: arbiter FSM states and the
// registered external bus request bundle.
package zacore_common;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DATA,
        ARB_FETCH,
        ARB_RESP
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_bus_req_t;

    localparam logic [3:0] STARVE_SAT = 4'hF;

endpackage

// File: rtl/zacore_mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the data port for
// one external memory bus. Data has priority; a starvation counter forces fetch.
module zacore_mem_arbiter
    import zacore_common::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic [31:0] o_fetch_data,
    output logic        o_fetch_valid,
    output logic        o_fetch_stall,
    input  logic        i_data_read_req,
    input  logic        i_data_write_req,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_write,
    input  logic [3:0]  i_data_write_mask,
    output logic [31:0] o_data_read,
    output logic        o_data_valid,
    output logic        o_data_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_invalidate,
    output arb_state_t  o_state
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Handshake: a requester raises its req and holds it (with stable address
    // and write data) until its one-cycle valid; the bus holds req/we/addr/
    // wdata/wmask stable until a one-cycle ack, rdata being valid with the ack.

    arb_state_t   state_q, state_d;
    logic [3:0]   starve_q;
    logic         drop_q;
    logic         resp_fetch_q;
    mem_bus_req_t bus_q;

    logic data_req;
    logic starved;
    logic grant_fetch;
    logic grant_data;

    assign data_req = i_data_read_req | i_data_write_req;
    assign starved  = i_fetch_req && (starve_q >= LIMIT);

    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == ARB_IDLE) begin
            grant_fetch = i_fetch_req && !i_invalidate && (!data_req || starved);
            grant_data  = data_req && !grant_fetch;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_data) begin
                    state_d = ARB_DATA;
                end else if (grant_fetch) begin
                    state_d = ARB_FETCH;
                end
            end
            ARB_DATA, ARB_FETCH: begin
                if (i_bus_ack) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            starve_q      <= '0;
            drop_q        <= 1'b0;
            resp_fetch_q  <= 1'b0;
            bus_q         <= '0;
            o_bus_req     <= 1'b0;
            o_fetch_data  <= '0;
            o_fetch_valid <= 1'b0;
            o_data_read   <= '0;
            o_data_valid  <= 1'b0;
        end else begin
            o_fetch_valid <= 1'b0;
            o_data_valid  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_data) begin
                        // A simultaneous read+write request is served as the write.
                        o_bus_req    <= 1'b1;
                        resp_fetch_q <= 1'b0;
                        bus_q.we     <= i_data_write_req;
                        bus_q.addr   <= i_data_addr;
                        bus_q.wdata  <= i_data_write_req ? i_data_write : 32'h0;
                        bus_q.wmask  <= i_data_write_req ? i_data_write_mask : 4'h0;
                    end else if (grant_fetch) begin
                        o_bus_req    <= 1'b1;
                        resp_fetch_q <= 1'b1;
                        bus_q        <= '{we: 1'b0, addr: i_fetch_addr, wdata: 32'h0, wmask: 4'h0};
                    end
                    if (grant_fetch || !i_fetch_req) begin
                        starve_q <= '0;
                    end else if (grant_data && starve_q != STARVE_SAT) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                ARB_DATA, ARB_FETCH: begin
                    if (state_q == ARB_FETCH && i_invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (resp_fetch_q) begin
                            o_fetch_data  <= i_bus_rdata;
                            o_fetch_valid <= !(drop_q || i_invalidate);
                        end else begin
                            o_data_read  <= bus_q.we ? 32'h0 : i_bus_rdata;
                            o_data_valid <= 1'b1;
                        end
                    end
                end
                ARB_RESP: drop_q <= 1'b0;
                default:  drop_q <= 1'b0;
            endcase
        end
    end

    assign o_bus_we    = bus_q.we;
    assign o_bus_addr  = bus_q.addr;
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_wmask = bus_q.wmask;
    assign o_state     = state_q;

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign o_fetch_stall = i_rst && i_fetch_req && !o_fetch_valid;
    assign o_data_stall  = i_rst && data_req && !o_data_valid;

    a_one_data_req : assert property (@(posedge i_clk) disable iff (!i_rst)
        !(i_data_read_req && i_data_write_req))
        else $warning("zacore_mem_arbiter: read and write requested together, serving as write");

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Directed bench for zacore_mem_arbiter: a table of single transactions plus
// hand-written sequences for starvation, invalidate and mid-transaction reset.
module tb_zacore_mem_arbiter;
    import zacore_common::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_data;
    logic        fetch_valid, fetch_stall;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [3:0]  data_mask = '0;
    logic [31:0] data_read;
    logic        data_valid, data_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        inval = 1'b0;
    arb_state_t  state;

    int n_total = 0;
    int n_pass  = 0;

    zacore_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_data(fetch_data), .o_fetch_valid(fetch_valid), .o_fetch_stall(fetch_stall),
        .i_data_read_req(rd_req), .i_data_write_req(wr_req),
        .i_data_addr(data_addr), .i_data_write(data_wdata), .i_data_write_mask(data_mask),
        .o_data_read(data_read), .o_data_valid(data_valid), .o_data_stall(data_stall),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_wmask(bus_wmask),
        .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
        .i_invalidate(inval), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          wait_cyc;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_resp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One transaction from IDLE; bus request bundle, stall, response and return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [70:0] exp_bus;
        exp_bus = {1'b1, v.exp_we, v.addr, (v.exp_we ? v.wdata : 32'h0), (v.exp_we ? v.mask : 4'h0)};
        if (v.is_fetch) begin
            fetch_req  = 1'b1;
            fetch_addr = v.addr;
        end else begin
            rd_req     = v.rd;
            wr_req     = v.wr;
            data_addr  = v.addr;
            data_wdata = v.wdata;
            data_mask  = v.mask;
        end
        tick();
        chk({tag, "_grant_state"}, 72'(state), 72'(v.is_fetch ? ARB_FETCH : ARB_DATA));
        chk({tag, "_bus"}, 72'({bus_req, bus_we, bus_addr, bus_wdata, bus_wmask}), 72'(exp_bus));
        for (int i = 0; i < v.wait_cyc; i++) begin
            tick();
            chk({tag, "_bus_hold"}, 72'({bus_req, bus_we, bus_addr, bus_wdata, bus_wmask}), 72'(exp_bus));
            chk({tag, "_stall"}, 72'({fetch_stall, data_stall}), 72'(v.is_fetch ? 2'b10 : 2'b01));
        end
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk({tag, "_valid"}, 72'({fetch_valid, data_valid, bus_req}), 72'(v.is_fetch ? 3'b100 : 3'b010));
        chk({tag, "_resp"}, 72'(v.is_fetch ? fetch_data : data_read), 72'(v.exp_resp));
        chk({tag, "_stall_at_valid"}, 72'({fetch_stall, data_stall}), 72'(0));
        fetch_req = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        tick();
        chk({tag, "_idle"}, 72'({state, fetch_valid, data_valid}), 72'({ARB_IDLE, 2'b00}));
    endtask

    bit exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int grants;
        //               fetch rd    wr    addr          wdata         mask  wt rdata         we    resp
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 3, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0,        4'h0, 0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,        4'h0, 0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0055, 4'hF, 1, 32'h9999_9999, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0,        4'h0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};

        // Reset state.
        tick();
        tick();
        chk("reset_outputs", 72'({bus_req, bus_we, bus_addr, fetch_valid, data_valid, fetch_stall, data_stall}), 72'(0));
        chk("reset_state", 72'(state), 72'(ARB_IDLE));
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held high on a zero-wait bus.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0800;
        rd_req     = 1'b1;
        data_addr  = 32'h0000_0200;
        grants     = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            tick();
            bus_ack = 1'b0;
            if (bus_req && state != ARB_RESP && !bus_ack) begin
                chk($sformatf("starve_grant%0d", grants), 72'(state == ARB_FETCH), 72'(exp_order[grants]));
                grants++;
                bus_ack   = 1'b1;
                bus_rdata = 32'h0000_1000 + 32'(grants);
                if (grants == 10) begin
                    fetch_req = 1'b0;
                    rd_req    = 1'b0;
                end
            end
        end
        chk("starve_grant_count", 72'(grants), 72'(10));
        tick();
        bus_ack = 1'b0;
        tick();
        chk("starve_idle", 72'(state), 72'(ARB_IDLE));

        // Invalidate while a fetch waits on the bus.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0500;
        tick();
        chk("inv_grant", 72'({state, bus_req}), 72'({ARB_FETCH, 1'b1}));
        inval = 1'b1;
        tick();
        inval = 1'b0;
        chk("inv_bus_held", 72'(bus_req), 72'(1));
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        tick();
        bus_ack = 1'b0;
        chk("inv_suppressed", 72'({state, fetch_valid, fetch_stall}), 72'({ARB_RESP, 1'b0, 1'b1}));
        fetch_req = 1'b0;
        tick();
        chk("inv_idle", 72'(state), 72'(ARB_IDLE));
        run_vec(vecs[2], "inv_next_fetch");

        // Reset asserted with a load in flight.
        rd_req    = 1'b1;
        data_addr = 32'h0000_0040;
        tick();
        chk("rst_mid_bus_req", 72'(bus_req), 72'(1));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", 72'({bus_req, bus_we, bus_addr, data_valid, data_stall, data_read}), 72'(0));
        chk("rst_mid_state", 72'(state), 72'(ARB_IDLE));
        rd_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_vec(vecs[3], "post_reset_load");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/zacore_mem_arbiter.md
# zacore_mem_arbiter

Shares the single external memory bus between the instruction-fetch port and the data port driven by `zacore_memory`. Grants one outstanding transaction at a time and holds bus signals stable until the bus acknowledges. Returns the read data and a one-cycle valid to the granted requester, and stalls the other requester. Data accesses have priority. A starvation counter guarantees fetch progress, and fetch responses are discarded after an `i_invalidate`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: the number of consecutive data grants allowed while fetch is waiting. The legal range is 1 to 15.

Ports:
- `i_clk`  in  1  the single clock. All flops are rising-edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_fetch_req`  in  1  fetch request. Held high until `o_fetch_valid`.
- `i_fetch_addr`  in  32  fetch address. Stable while `i_fetch_req` is high.
- `o_fetch_data`  out  32  fetch read data. Meaningful only with `o_fetch_valid`.
- `o_fetch_valid`  out  1  one-cycle fetch completion pulse.
- `o_fetch_stall`  out  1  fetch is waiting.
- `i_data_read_req`, `i_data_write_req`  in  1 each  data port requests. At most one is high at a time. Each is held until `o_data_valid`.
- `i_data_addr`  in  32  data address.
- `i_data_write`  in  32  data to write.
- `i_data_write_mask`  in  4  byte enables for the write.
- `o_data_read`  out  32  load data. Zero on write completion.
- `o_data_valid`  out  1  one-cycle data completion pulse, for loads and stores.
- `o_data_stall`  out  1  data port is waiting.
- `o_bus_req`, `o_bus_we`  out  1 each  bus request and write enable.
- `o_bus_addr`  out  32  bus address.
- `o_bus_wdata`  out  32  bus write data.
- `o_bus_wmask`  out  4  bus byte enables.
- `i_bus_ack`  in  1  one-cycle bus acknowledge.
- `i_bus_rdata`  in  32  bus read data. Valid in the `i_bus_ack` cycle.
- `i_invalidate`  in  1  pipeline flush.

## Operation
- FSM states are IDLE, DATA, FETCH and RESP.
- **IDLE: arbitration.**
  - Data wins if requesting, unless the starvation counter is at `STARVE_LIMIT` and fetch is requesting.
  - Fetch may be granted only when `i_invalidate` is low.
  - The winner moves the FSM to DATA or FETCH and loads the bus registers (addr/we/wdata/wmask) with `o_bus_req` set to 1.
- **DATA and FETCH:** hold all bus outputs constant until `i_bus_ack`. On ack:
  - drop `o_bus_req`;
  - latch `i_bus_rdata` into the owner's data register (0 for a store);
  - go to RESP.
- **RESP:** pulse the owner's valid for exactly one cycle, then go to IDLE. No grant is made in RESP, so the requester drops its request before the next arbitration.
- **Invalidate:**
  - If `i_invalidate` is high in any cycle while the FSM is in FETCH, set `drop`. The bus transaction still completes, but `o_fetch_valid` is suppressed in RESP.
  - `drop` clears on entry to IDLE.
  - `i_invalidate` during DATA has no effect, so stores always complete.
- **Starvation counter** (width 4, saturating):
  - increments on each data grant made while `i_fetch_req` is high;
  - clears on a fetch grant, or in any IDLE cycle with `i_fetch_req` low.
- **Stalls (combinational):** `o_x_stall` = `i_x_req` && !`o_x_valid`.
- **Illegal request:** `i_data_read_req` and `i_data_write_req` high together is illegal. An assertion fires, and the request is treated as a write.
- **Reset:**
  - FSM goes to IDLE; counter and `drop` clear.
  - All outputs are 0.
  - Reset asserted mid-transaction abandons it; the bus must tolerate a dropped `o_bus_req`.

## Timing
- Request seen in IDLE at cycle N:
  - `o_bus_req` high at N+1;
  - earliest `i_bus_ack` at N+1;
  - valid at N+2;
  - IDLE at N+3, with the next grant's `o_bus_req` at N+4.
- Back-to-back throughput is therefore one transaction per 3 cycles at zero bus wait.
- Each wait cycle on `i_bus_ack` adds one cycle of latency.
- All bus outputs, `o_*_data` and `o_*_valid` are registered.

## Structure
- Add to `zacore_common`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_FETCH, ARB_RESP} arb_state_t`;
  - `typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;} mem_bus_req_t`.
- Flat module with no sub-module. The counter and the FSM live inline.

## Test plan
- Single load at addr 0x100; bus acks 2 cycles after `o_bus_req` with rdata 0xDEADBEEF → `o_data_valid` is one pulse, `o_data_read`=0xDEADBEEF, `o_fetch_stall` stays low.
- Fetch and data requests both high continuously, `STARVE_LIMIT`=4, zero-wait bus → grant order is D,D,D,D,F,D,D,D,D,F; counter never exceeds 4.
- Store at 0x20, data 0x11223344, mask 0b0101 → `o_bus_we`=1, addr/wdata/wmask stable through 3 wait cycles, `o_data_valid` pulses with `o_data_read`=0.
- Fetch in flight; `i_invalidate` pulses during the wait → bus completes, `o_fetch_valid` stays 0, the next fetch request is served normally.
- Reset (`i_rst`=0) asserted while in DATA with `o_bus_req`=1 → all outputs are 0 immediately (asynchronous); after release, a new load completes from IDLE.
- Both data request bits high → assertion fires, `o_bus_we`=1.
